// File: rtl/uart_tx_fifo.sv
//------------------------------------------------------------------------------
// uart_tx_fifo : buffered UART transmitter, configurable frame, baud-tick paced
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          baud_tick,
    input  logic                          wr_en,
    input  logic [DATA_BITS-1:0]          wr_data,
    output logic                          tx,
    output logic                          busy,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(OVERSAMPLE);

    localparam logic [AW:0]   DEPTH_L   = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] TICK_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW:0]          wptr;
    logic [AW:0]          rptr;
    logic [DATA_BITS-1:0] head;
    logic                 push;
    logic                 pop;

    logic [2:0]           state;
    logic [2:0]           state_next;
    logic [CW-1:0]        tick_cnt;
    logic [CW-1:0]        tick_next;
    logic [2:0]           bit_idx;
    logic [2:0]           bit_next;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] shift_next;
    logic                 par_bit;
    logic                 par_next;
    logic                 tx_next;
    logic                 bit_end;

    // full is taken from the registered pointers, so a same-cycle pop cannot free a slot
    assign level    = wptr - rptr;
    assign full     = (level == DEPTH_L);
    assign empty    = (level == '0);
    assign push     = wr_en && !full;
    assign overflow = wr_en && full;
    assign head     = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    assign bit_end = baud_tick && (tick_cnt == TICK_LAST) && (state != S_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            par_bit  <= 1'b0;
            tx       <= 1'b1;
        end else begin
            tick_cnt <= tick_next;
            bit_idx  <= bit_next;
            shift    <= shift_next;
            par_bit  <= par_next;
            tx       <= tx_next;
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        tick_next  = tick_cnt;
        bit_next   = bit_idx;
        shift_next = shift;
        par_next   = par_bit;
        if ((state != S_IDLE) && baud_tick) begin
            tick_next = bit_end ? '0 : tick_cnt + 1'b1;
        end
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_next = shift >> 1;
                    if (bit_idx == DATA_LAST) begin
                        bit_next   = '0;
                        state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_next = bit_idx + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (bit_idx == STOP_LAST) begin
                        bit_next = '0;
                        if (!empty) begin
                            pop = 1'b1;
                        end else begin
                            state_next = S_IDLE;
                        end
                    end else begin
                        bit_next = bit_idx + 1'b1;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
        // a pop always starts a fresh frame, also straight out of the last stop bit
        if (pop) begin
            state_next = S_START;
            tick_next  = '0;
            bit_next   = '0;
            shift_next = head;
            par_next   = (PARITY_ODD != 0) ? ~(^head) : (^head);
        end
    end

    // tx is derived from the next state so the line is registered yet aligned with the state change
    always_comb begin
        tx_next = 1'b1;
        busy    = (state != S_IDLE);
        case (state_next)
            S_START:  tx_next = 1'b0;
            S_DATA:   tx_next = shift_next[0];
            S_PARITY: tx_next = par_next;
            default:  tx_next = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
//------------------------------------------------------------------------------
// tb_uart_tx_fifo : directed self-checking bench for uart_tx_fifo
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       baud_tick = 1'b0;
    logic       wr_en_a = 1'b0, wr_en_b = 1'b0, wr_en_c = 1'b0;
    logic [7:0] wr_data_a = '0, wr_data_c = '0;
    logic [6:0] wr_data_b = '0;
    logic       tx_a, busy_a, full_a, empty_a, overflow_a;
    logic       tx_b, busy_b, full_b, empty_b, overflow_b;
    logic       tx_c, busy_c, full_c, empty_c, overflow_c;
    logic [2:0] level_a, level_b, level_c;
    logic       tx_m, busy_m;

    int n_assert = 0;
    int n_fail = 0;
    int tick_count = 0;
    int div = 0;
    int sel = 0;

    uart_tx_fifo dut_a (
        .clk(clk), .reset(reset), .baud_tick(baud_tick), .wr_en(wr_en_a), .wr_data(wr_data_a),
        .tx(tx_a), .busy(busy_a), .full(full_a), .empty(empty_a), .level(level_a), .overflow(overflow_a)
    );

    uart_tx_fifo #(.DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut_b (
        .clk(clk), .reset(reset), .baud_tick(baud_tick), .wr_en(wr_en_b), .wr_data(wr_data_b),
        .tx(tx_b), .busy(busy_b), .full(full_b), .empty(empty_b), .level(level_b), .overflow(overflow_b)
    );

    uart_tx_fifo #(.PARITY_EN(1), .PARITY_ODD(1)) dut_c (
        .clk(clk), .reset(reset), .baud_tick(baud_tick), .wr_en(wr_en_c), .wr_data(wr_data_c),
        .tx(tx_c), .busy(busy_c), .full(full_c), .empty(empty_c), .level(level_c), .overflow(overflow_c)
    );

    always #5 clk = ~clk;

    // one baud_tick every 4 clk, changed on the falling edge
    always @(negedge clk) begin
        div = (div + 1) % 4;
        baud_tick = (div == 0);
    end

    always @(posedge clk) begin
        if (baud_tick) tick_count++;
    end

    always_comb begin
        tx_m   = (sel == 0) ? tx_a   : (sel == 1) ? tx_b   : tx_c;
        busy_m = (sel == 0) ? busy_a : (sel == 1) ? busy_b : busy_c;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_tick(input int target);
        while (tick_count < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    // entered just after the edge that began the start bit, whose tick stamp is t0
    task automatic rx_frame(input string tag, input logic [7:0] val, input int nd, input int pe,
                            input logic pbit, input int ns, input int t0);
        int k = 1;
        chk($sformatf("%s start", tag), tx_m, 1'b0);
        for (int i = 0; i < nd; i++) begin
            wait_tick(t0 + 16 * k);
            k++;
            chk($sformatf("%s d%0d", tag, i), tx_m, val[i]);
        end
        if (pe != 0) begin
            wait_tick(t0 + 16 * k);
            k++;
            chk($sformatf("%s parity", tag), tx_m, pbit);
        end
        for (int i = 0; i < ns; i++) begin
            wait_tick(t0 + 16 * k);
            k++;
            chk($sformatf("%s stop%0d", tag, i), tx_m, 1'b1);
            chk($sformatf("%s busy%0d", tag, i), busy_m, 1'b1);
        end
        wait_tick(t0 + 16 * k);
    endtask

    initial begin
        int t0;
        int lows;
        logic [7:0] ovd [6];
        logic [2:0] lv [6];
        ovd = '{8'h3C, 8'hA5, 8'h01, 8'hF0, 8'h96, 8'hEE};
        lv  = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4};

        repeat (3) @(posedge clk);
        #1;
        chk("rst tx", tx_a, 1'b1);
        chk("rst busy", busy_a, 1'b0);
        chk("rst full", full_a, 1'b0);
        chk("rst empty", empty_a, 1'b1);
        chk("rst level", level_a, 3'd0);
        chk("rst overflow", overflow_a, 1'b0);
        chk("rst tx_b", tx_b, 1'b1);
        chk("rst tx_c", tx_c, 1'b1);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // basic 8N1 frame of 0x55
        sel = 0;
        wr_en_a = 1'b1; wr_data_a = 8'h55;
        @(posedge clk); #1;
        wr_en_a = 1'b0; wr_data_a = 8'h00;
        chk("basic empty N", empty_a, 1'b0);
        chk("basic level N", level_a, 3'd1);
        chk("basic tx N", tx_a, 1'b1);
        chk("basic busy N", busy_a, 1'b0);
        @(posedge clk); #1;
        t0 = tick_count;
        chk("basic busy N1", busy_a, 1'b1);
        chk("basic empty N1", empty_a, 1'b1);
        chk("basic level N1", level_a, 3'd0);
        rx_frame("basic", 8'h55, 8, 0, 1'b0, 1, t0);
        chk("basic tx end", tx_a, 1'b1);
        chk("basic busy end", busy_a, 1'b0);

        // overflow: six writes into a depth-4 FIFO while idle
        for (int i = 0; i < 6; i++) begin
            wr_en_a = 1'b1; wr_data_a = ovd[i];
            #1;
            chk($sformatf("ovf level w%0d", i), level_a, lv[i]);
            chk($sformatf("ovf pulse w%0d", i), overflow_a, (i == 5));
            @(posedge clk); #1;
            if (i == 1) t0 = tick_count;
        end
        wr_en_a = 1'b0;
        #1;
        chk("ovf pulse after", overflow_a, 1'b0);
        chk("ovf level after", level_a, 3'd4);
        chk("ovf full after", full_a, 1'b1);
        for (int f = 0; f < 5; f++) begin
            rx_frame($sformatf("ovf f%0d", f), ovd[f], 8, 0, 1'b0, 1, t0 + 160 * f);
        end
        chk("ovf tx end", tx_a, 1'b1);
        chk("ovf busy end", busy_a, 1'b0);
        chk("ovf empty end", empty_a, 1'b1);

        // back-to-back 7E2 frames
        sel = 1;
        wr_en_b = 1'b1; wr_data_b = 7'h41;
        @(posedge clk); #1;
        chk("b2b level 1", level_b, 3'd1);
        wr_data_b = 7'h42;
        @(posedge clk); #1;
        t0 = tick_count;
        chk("b2b level 2", level_b, 3'd1);
        wr_data_b = 7'h43;
        @(posedge clk); #1;
        wr_en_b = 1'b0;
        chk("b2b level 3", level_b, 3'd2);
        rx_frame("b2b f0", 8'h41, 7, 1, 1'b0, 2, t0);
        chk("b2b level f1", level_b, 3'd1);
        chk("b2b busy f1", busy_b, 1'b1);
        rx_frame("b2b f1", 8'h42, 7, 1, 1'b0, 2, t0 + 176);
        chk("b2b level f2", level_b, 3'd0);
        rx_frame("b2b f2", 8'h43, 7, 1, 1'b1, 2, t0 + 352);
        chk("b2b tx end", tx_b, 1'b1);
        chk("b2b busy end", busy_b, 1'b0);

        // even parity, two stop bits
        wr_en_b = 1'b1; wr_data_b = 7'h07;
        @(posedge clk); #1;
        wr_en_b = 1'b0;
        @(posedge clk); #1;
        t0 = tick_count;
        rx_frame("even", 8'h07, 7, 1, 1'b1, 2, t0);
        chk("even busy end", busy_b, 1'b0);

        // odd parity, one stop bit
        sel = 2;
        wr_en_c = 1'b1; wr_data_c = 8'h07;
        @(posedge clk); #1;
        wr_en_c = 1'b0; wr_data_c = 8'hFF;
        @(posedge clk); #1;
        t0 = tick_count;
        rx_frame("odd", 8'h07, 8, 1, 1'b0, 1, t0);
        chk("odd busy end", busy_c, 1'b0);

        // reset in the middle of a data bit with two bytes queued
        sel = 0;
        wr_en_a = 1'b1; wr_data_a = 8'h00;
        @(posedge clk); #1;
        wr_data_a = 8'hFF;
        @(posedge clk); #1;
        t0 = tick_count;
        @(posedge clk); #1;
        wr_en_a = 1'b0;
        wait_tick(t0 + 24);
        chk("mid tx before", tx_a, 1'b0);
        chk("mid level before", level_a, 3'd2);
        #2;
        reset = 1'b0;
        #1;
        chk("mid tx async", tx_a, 1'b1);
        chk("mid empty async", empty_a, 1'b1);
        chk("mid level async", level_a, 3'd0);
        chk("mid busy async", busy_a, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        lows = 0;
        repeat (400) begin
            @(posedge clk); #1;
            if (tx_a !== 1'b1 || busy_a !== 1'b0) lows++;
        end
        chk("mid idle after", lows, 0);
        wr_en_a = 1'b1; wr_data_a = 8'hA3;
        @(posedge clk); #1;
        wr_en_a = 1'b0;
        @(posedge clk); #1;
        t0 = tick_count;
        rx_frame("post rst", 8'hA3, 8, 0, 1'b0, 1, t0);
        chk("post rst busy end", busy_a, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
